// File: rtl/uart_prog_loader_pkg.sv
// Shared widths and UART receive state encoding for the boot program loader.
// No logic; constants and types only.
// No flow control.
package uart_prog_loader_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART byte receiver with input synchronizer and stop-bit check.
// Latency: rx_valid/rx_frame_err pulse one clk after the mid-stop-bit sample.
// No backpressure: each received byte is offered for exactly one cycle.
module uart_rx
    import uart_prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_line,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       rx_frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic            rx_meta;
    logic            rx_s;
    rx_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;

    // Line idles high, so the synchronizer resets to 1 to avoid a fake start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_line;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= RX_IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            rx_valid     <= 1'b0;
            rx_byte      <= '0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= RX_START;
                end
                RX_START: begin
                    // Re-check at mid start bit; a high line here was only a glitch.
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[7:1]};
                        if (bit_idx == 3'd7) state <= RX_STOP;
                        else                 bit_idx <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            rx_valid <= 1'b1;
                            rx_byte  <= shreg;
                            state    <= RX_IDLE;
                        end else begin
                            rx_frame_err <= 1'b1;
                            state        <= RX_WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RX_WAIT_IDLE: begin
                    if (rx_s) state <= RX_IDLE;
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_prog_loader.sv
// Boot loader: UART bytes -> little-endian 32-bit words -> sequential imem writes.
// Latency: imem_we one clk after the 4th rx_valid; load_done one clk after the last write.
// No backpressure: imem accepts every write; bytes after load_done are dropped.
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 4,
    parameter int CELL_NUMBERS   = 16,
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 64 * CLKS_PER_BIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx_i,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              load_done,
    output logic              frame_err
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELL_NUMBERS - 1);

    logic                             rx_valid;
    logic [7:0]                       rx_byte;
    logic                             rx_frame_err;
    logic [1:0]                       byte_cnt;
    logic [WORD_W-9:0]                word_buf;
    logic [ADDR_W-1:0]                word_idx;
    logic [TO_W-1:0]                  tcnt;

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk          (clk),
        .rst          (rst),
        .rx_line      (uart_rx_i),
        .rx_valid     (rx_valid),
        .rx_byte      (rx_byte),
        .rx_frame_err (rx_frame_err)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            load_done  <= 1'b0;
            frame_err  <= 1'b0;
            byte_cnt   <= '0;
            word_buf   <= '0;
            word_idx   <= '0;
            tcnt       <= '0;
        end else begin
            imem_we <= 1'b0;
            if (rx_frame_err) frame_err <= 1'b1;
            if (imem_we && imem_addr == LAST_ADDR) load_done <= 1'b1;

            if (!load_done) begin
                // rx_valid outranks an expiring timeout so the byte is never lost.
                if (rx_valid) begin
                    tcnt     <= '0;
                    byte_cnt <= byte_cnt + 2'd1;
                    case (byte_cnt)
                        2'd0: word_buf[7:0]   <= rx_byte;
                        2'd1: word_buf[15:8]  <= rx_byte;
                        2'd2: word_buf[23:16] <= rx_byte;
                        default: begin
                            imem_we    <= 1'b1;
                            imem_addr  <= word_idx;
                            imem_wdata <= {rx_byte, word_buf};
                            word_idx   <= word_idx + ADDR_W'(1);
                        end
                    endcase
                end else if (rx_frame_err) begin
                    byte_cnt <= '0;
                    tcnt     <= '0;
                end else if (byte_cnt != 2'd0) begin
                    if (tcnt == TO_LAST) begin
                        byte_cnt <= '0;
                        tcnt     <= '0;
                    end else begin
                        tcnt <= tcnt + TO_W'(1);
                    end
                end else begin
                    tcnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench: directed plan vectors plus randomized byte streams vs a queue model.
module tb_uart_prog_loader;

    localparam int CPB   = 4;
    localparam int CELLS = 2;
    localparam int TO    = 256;
    localparam int AW    = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rxd = 1'b1;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          load_done;
    logic          frame_err;

    always #5 clk = ~clk;

    uart_prog_loader #(
        .CLKS_PER_BIT   (CPB),
        .CELL_NUMBERS   (CELLS),
        .ADDR_W         (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_rx_i  (rxd),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .load_done  (load_done),
        .frame_err  (frame_err)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int last_we_cyc = 0;
    int done_rise_cyc = 0;
    int rxv_cnt = 0;
    logic prev_done = 1'b0;
    logic [39:0] obs_q[$];
    logic [39:0] exp_q[$];

    // Reference model state: pending bytes of the current word, word count, sticky flags.
    logic [7:0] m_part[$];
    int         m_idx;
    bit         m_done;
    bit         m_ferr;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (imem_we) begin
            obs_q.push_back({imem_addr, imem_wdata});
            last_we_cyc = cyc;
        end
        if (load_done && !prev_done) done_rise_cyc = cyc;
        prev_done = load_done;
        if (dut.rx_valid) rxv_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_part.delete();
        exp_q.delete();
        m_idx  = 0;
        m_done = 0;
        m_ferr = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (!m_done) begin
            m_part.push_back(b);
            if (m_part.size() == 4) begin
                exp_q.push_back({AW'(m_idx), m_part[3], m_part[2], m_part[1], m_part[0]});
                m_part.delete();
                m_idx++;
                if (m_idx == CELLS) m_done = 1;
            end
        end
    endtask

    task automatic hold_bit(input logic v);
        rxd = v;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(b[i]);
        hold_bit(stop_ok);
        if (!stop_ok) hold_bit(1'b1);
        rxd = 1'b1;
        if (stop_ok) model_byte(b);
        else begin
            m_ferr = 1;
            if (!m_done) m_part.delete();
        end
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(posedge clk);
        if (n >= TO && !m_done) m_part.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        rst = 1'b0;
        rxd = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        model_reset();
        obs_q.delete();
        @(posedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (imem_we !== 1'b0)    begin n_err++; $display("FAIL reset_we: got %b expected 0", imem_we); end
        n_cmp++; if (imem_addr !== '0)    begin n_err++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
        n_cmp++; if (imem_wdata !== '0)   begin n_err++; $display("FAIL reset_wdata: got %h expected 0", imem_wdata); end
        n_cmp++; if (load_done !== 1'b0)  begin n_err++; $display("FAIL reset_done: got %b expected 0", load_done); end
        n_cmp++; if (frame_err !== 1'b0)  begin n_err++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
        #1 rst = 1'b1;
        model_reset();
        obs_q.delete();
        @(posedge clk);
    endtask

    task automatic test_load();
        logic [7:0] w0 [4] = '{8'h93, 8'h80, 8'h70, 8'h00};
        logic [7:0] w1 [4] = '{8'h63, 8'hD4, 8'h20, 8'h00};
        do_reset();
        for (int i = 0; i < 4; i++) send_byte(w0[i], 1);
        idle(10);
        n_cmp++; if (obs_q.size() !== 1) begin n_err++; $display("FAIL load_w0_count: got %0d expected 1", obs_q.size()); end
        else begin
            n_cmp++; if (obs_q[0] !== 40'h00_00708093) begin n_err++; $display("FAIL load_w0: got %h expected 0000708093", obs_q[0]); end
        end
        n_cmp++; if (load_done !== 1'b0) begin n_err++; $display("FAIL load_done_early: got %b expected 0", load_done); end
        for (int i = 0; i < 4; i++) send_byte(w1[i], 1);
        idle(10);
        n_cmp++; if (obs_q.size() !== 2) begin n_err++; $display("FAIL load_w1_count: got %0d expected 2", obs_q.size()); end
        else begin
            n_cmp++; if (obs_q[1] !== 40'h01_0020D463) begin n_err++; $display("FAIL load_w1: got %h expected 010020d463", obs_q[1]); end
        end
        n_cmp++; if (load_done !== 1'b1) begin n_err++; $display("FAIL load_done: got %b expected 1", load_done); end
        n_cmp++; if (done_rise_cyc - last_we_cyc !== 1) begin n_err++; $display("FAIL done_latency: got %0d expected 1", done_rise_cyc - last_we_cyc); end
        n_cmp++; if ({imem_addr, imem_wdata} !== 40'h01_0020D463) begin n_err++; $display("FAIL hold_outputs: got %h expected 010020d463", {imem_addr, imem_wdata}); end
        send_byte(8'hFF, 1);
        idle(10);
        n_cmp++; if (obs_q.size() !== 2) begin n_err++; $display("FAIL after_done_write: got %0d writes expected 2", obs_q.size()); end
    endtask

    task automatic test_frame_err();
        logic [7:0] w [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        do_reset();
        send_byte(8'h55, 0);
        idle(10);
        n_cmp++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL ferr_set: got %b expected 1", frame_err); end
        n_cmp++; if (obs_q.size() !== 0) begin n_err++; $display("FAIL ferr_nowrite: got %0d expected 0", obs_q.size()); end
        for (int i = 0; i < 4; i++) send_byte(w[i], 1);
        idle(10);
        n_cmp++; if (obs_q.size() !== 1 || obs_q[0] !== 40'h00_DEADBEEF) begin n_err++; $display("FAIL ferr_word: got %0d writes first %h expected 1 x 00deadbeef", obs_q.size(), obs_q.size() ? obs_q[0] : 40'h0); end
    endtask

    task automatic test_timeout();
        logic [7:0] w [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        do_reset();
        send_byte(8'h11, 1);
        send_byte(8'h22, 1);
        idle(300);
        for (int i = 0; i < 4; i++) send_byte(w[i], 1);
        idle(10);
        n_cmp++; if (obs_q.size() !== 1 || obs_q[0] !== 40'h00_DEADBEEF) begin n_err++; $display("FAIL timeout_word: got %0d writes first %h expected 1 x 00deadbeef", obs_q.size(), obs_q.size() ? obs_q[0] : 40'h0); end
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL timeout_ferr: got %b expected 0", frame_err); end
    endtask

    task automatic test_glitch();
        int rxv0;
        logic [7:0] w [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
        do_reset();
        rxv0 = rxv_cnt;
        @(posedge clk); rxd = 1'b0;
        @(posedge clk); rxd = 1'b1;
        idle(60);
        n_cmp++; if (rxv_cnt - rxv0 !== 0) begin n_err++; $display("FAIL glitch_rxv: got %0d pulses expected 0", rxv_cnt - rxv0); end
        n_cmp++; if (obs_q.size() !== 0) begin n_err++; $display("FAIL glitch_write: got %0d expected 0", obs_q.size()); end
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL glitch_ferr: got %b expected 0", frame_err); end
        for (int i = 0; i < 4; i++) send_byte(w[i], 1);
        idle(10);
        n_cmp++; if (obs_q.size() !== 1 || obs_q[0] !== 40'h00_04030201) begin n_err++; $display("FAIL glitch_word: got %0d writes first %h expected 1 x 0004030201", obs_q.size(), obs_q.size() ? obs_q[0] : 40'h0); end
    endtask

    task automatic test_mid_reset();
        logic [7:0] w [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
        logic [7:0] b2 = 8'hA6;
        do_reset();
        for (int i = 0; i < 4; i++) send_byte(8'hC0 + 8'(i), 1);
        send_byte(8'h5A, 1);
        hold_bit(1'b0);
        for (int i = 0; i < 3; i++) hold_bit(b2[i]);
        rxd = b2[3];
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_cmp++; if ({imem_we, imem_addr, imem_wdata, load_done, frame_err} !== '0) begin n_err++; $display("FAIL midreset_outputs: got we=%b addr=%h wdata=%h done=%b ferr=%b expected all 0", imem_we, imem_addr, imem_wdata, load_done, frame_err); end
        rxd = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        model_reset();
        obs_q.delete();
        @(posedge clk);
        for (int i = 0; i < 4; i++) send_byte(w[i], 1);
        idle(10);
        n_cmp++; if (obs_q.size() !== 1 || obs_q[0] !== 40'h00_04030201) begin n_err++; $display("FAIL midreset_word: got %0d writes first %h expected 1 x 0004030201", obs_q.size(), obs_q.size() ? obs_q[0] : 40'h0); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            do_reset();
            for (int k = 0; k < 13; k++) begin
                bit ok;
                ok = ($urandom_range(0, 7) != 0);
                send_byte(8'($urandom), ok);
                if ($urandom_range(0, 9) == 0) idle(300);
                else idle($urandom_range(0, 30));
            end
            idle(10);
            n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL rand_count it%0d: got %0d expected %0d", it, obs_q.size(), exp_q.size()); end
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
                n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand_word it%0d/%0d: got %h expected %h", it, i, obs_q[i], exp_q[i]); end
            end
            n_cmp++; if (load_done !== m_done) begin n_err++; $display("FAIL rand_done it%0d: got %b expected %b", it, load_done, m_done); end
            n_cmp++; if (frame_err !== m_ferr) begin n_err++; $display("FAIL rand_ferr it%0d: got %b expected %b", it, frame_err, m_ferr); end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_frame_err();
        test_timeout();
        test_glitch();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
